apple_bus_sampler: RTL and testbench

Parametrised Apple II bus sampler that generalises the fixed-offset address/data latch. It counts `clk_logic_i` cycles from each Phi1 edge and samples address, R/W and data at offsets programmable at run time, with an optional 3-sample majority vote on data. Qualifying bus cycles are pushed into a depth-parametrised, address-filtered capture FIFO. It sits between the bus timing generator and the card/monitor logic, and also produces the bus-idle (sleep) indication.

---
 rtl/apple_bus_sampler.sv | 175 +++++++++++++++++
 tb/tb_apple_bus_sampler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_bus_sampler.sv
// apple_bus_sampler: Apple II bus address/data sampler with programmable
// phase offsets, optional 3-sample data vote and an address-filtered FIFO.
//
// Ports:
//   clk_logic_i, system_reset_i       logic clock, async active-high reset
//   phi1_i, phi1_posedge_i/negedge_i  Phi1 level and 1-cycle edge pulses
//   a2_a_i, a2_d_i, a2_rw_n_i         raw bus address, data, R/W
//   cfg_addr_count_i/cfg_data_count_i sample offsets in Phi1 / Phi0
//   addr_o, rw_n_o, addr_strobe_o     latched address cycle
//   data_o, data_in_strobe_o          latched data, per-sample pulse
//   fifo_rd_i, fifo_dout_o, fifo_empty_o, fifo_count_o  capture FIFO
//   overflow_o, overflow_clr_i        sticky dropped-push flag
//   sleep_o                           phase counter saturated (bus idle)
module apple_bus_sampler #(
    parameter int          CNT_W         = 6,
    parameter int          DEPTH         = 16,
    parameter int          DATA_VOTE     = 0,
    parameter int          CAPTURE_READS = 0,
    parameter logic [15:0] FILTER_LO     = 16'h0000,
    parameter logic [15:0] FILTER_HI     = 16'hFFFF
) (
    input  logic                     clk_logic_i,
    input  logic                     system_reset_i,
    input  logic                     phi1_i,
    input  logic                     phi1_posedge_i,
    input  logic                     phi1_negedge_i,
    input  logic [15:0]              a2_a_i,
    input  logic [7:0]               a2_d_i,
    input  logic                     a2_rw_n_i,
    input  logic [CNT_W-1:0]         cfg_addr_count_i,
    input  logic [CNT_W-1:0]         cfg_data_count_i,
    output logic [15:0]              addr_o,
    output logic                     rw_n_o,
    output logic                     addr_strobe_o,
    output logic [7:0]               data_o,
    output logic                     data_in_strobe_o,
    input  logic                     fifo_rd_i,
    output logic [24:0]              fifo_dout_o,
    output logic                     fifo_empty_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     overflow_o,
    input  logic                     overflow_clr_i,
    output logic                     sleep_o
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW:0]      FULL_N  = (AW+1)'(DEPTH);

    logic [CNT_W-1:0] cnt;
    logic             addr_hit;
    logic             data_hit;
    logic [7:0]       d_q1;
    logic [7:0]       d_q2;
    logic [7:0]       vote;
    logic             use_vote;
    logic [7:0]       sample;
    logic             data_upd;
    logic [16:0]      lo_diff;
    logic [16:0]      hi_diff;
    logic             in_win;
    logic             push;
    logic             full;
    logic             pop_ok;
    logic             push_ok;
    logic             ovf_set;
    logic [24:0]      mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    // Phase counter: restarts on either Phi1 edge, saturates when idle.
    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            cnt <= CNT_MAX;
        end else if (phi1_posedge_i || phi1_negedge_i) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sleep_o = (cnt == CNT_MAX);

    // Compares use the pre-clear count, so an edge pulse in the
    // matching cycle does not suppress the sample.
    assign addr_hit = phi1_i && (cnt == cfg_addr_count_i);
    assign data_hit = !phi1_i && (cnt == cfg_data_count_i);

    // Two-deep history of the data bus for the majority vote.
    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            d_q1 <= '0;
            d_q2 <= '0;
        end else begin
            d_q1 <= a2_d_i;
            d_q2 <= d_q1;
        end
    end

    assign vote     = (d_q2 & d_q1) | (d_q2 & a2_d_i) | (d_q1 & a2_d_i);
    assign use_vote = (DATA_VOTE != 0) && (cfg_data_count_i >= CNT_W'(2));
    assign sample   = use_vote ? vote : a2_d_i;
    assign data_upd = data_hit && (!rw_n_o || (CAPTURE_READS != 0));

    // Window test via borrow bits avoids constant-compare corner cases.
    assign lo_diff = {1'b0, addr_o} - {1'b0, FILTER_LO};
    assign hi_diff = {1'b0, FILTER_HI} - {1'b0, addr_o};
    assign in_win  = !lo_diff[16] && !hi_diff[16];
    assign push    = data_upd && in_win;

    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            addr_o           <= '0;
            rw_n_o           <= 1'b1;
            addr_strobe_o    <= 1'b0;
            data_o           <= '0;
            data_in_strobe_o <= 1'b0;
        end else begin
            addr_strobe_o    <= addr_hit;
            data_in_strobe_o <= data_hit;
            if (addr_hit) begin
                addr_o <= a2_a_i;
                rw_n_o <= a2_rw_n_i;
            end
            if (data_upd) begin
                data_o <= sample;
            end
        end
    end

    // Capture FIFO. A pop frees the slot the same cycle, so push+pop
    // while full both succeed.
    assign full    = (count == FULL_N);
    assign pop_ok  = fifo_rd_i && (count != '0);
    assign push_ok = push && (!full || pop_ok);
    assign ovf_set = push && !push_ok;

    always_ff @(posedge clk_logic_i) begin
        if (push_ok) begin
            mem[wptr] <= {rw_n_o, addr_o, sample};
        end
    end

    always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
        if (system_reset_i) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    assign fifo_empty_o = (count == '0);
    assign fifo_count_o = count;
    assign fifo_dout_o  = (count == '0) ? 25'd0 : mem[rptr];

endmodule

// File: tb/tb_apple_bus_sampler.sv
// tb_apple_bus_sampler: directed bench for apple_bus_sampler using two
// instances (plain/DEPTH 4 and vote/capture-reads/filtered).
module tb_apple_bus_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phi1 = 1'b0;
    logic        phi1_pe = 1'b0;
    logic        phi1_ne = 1'b0;
    logic [15:0] a2_a = '0;
    logic [7:0]  a2_d = '0;
    logic        a2_rw_n = 1'b1;
    logic [5:0]  cfg_a = 6'd18;
    logic [5:0]  cfg_d = 6'd15;
    logic        fifo_rd0 = 1'b0;
    logic        fifo_rd1 = 1'b0;
    logic        ovf_clr0 = 1'b0;
    logic        ovf_clr1 = 1'b0;

    logic [15:0] addr0, addr1;
    logic        rw0, rw1, as0, as1, ds0, ds1;
    logic [7:0]  data0, data1;
    logic [24:0] dout0, dout1;
    logic        empty0, empty1, ovf0, ovf1, sleep0, sleep1;
    logic [2:0]  cnt0;
    logic [4:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apple_bus_sampler #(
        .CNT_W(6), .DEPTH(4), .DATA_VOTE(0), .CAPTURE_READS(0),
        .FILTER_LO(16'h0000), .FILTER_HI(16'hFFFF)
    ) dut0 (
        .clk_logic_i(clk), .system_reset_i(rst),
        .phi1_i(phi1), .phi1_posedge_i(phi1_pe), .phi1_negedge_i(phi1_ne),
        .a2_a_i(a2_a), .a2_d_i(a2_d), .a2_rw_n_i(a2_rw_n),
        .cfg_addr_count_i(cfg_a), .cfg_data_count_i(cfg_d),
        .addr_o(addr0), .rw_n_o(rw0), .addr_strobe_o(as0),
        .data_o(data0), .data_in_strobe_o(ds0),
        .fifo_rd_i(fifo_rd0), .fifo_dout_o(dout0), .fifo_empty_o(empty0),
        .fifo_count_o(cnt0), .overflow_o(ovf0),
        .overflow_clr_i(ovf_clr0), .sleep_o(sleep0)
    );

    apple_bus_sampler #(
        .CNT_W(6), .DEPTH(16), .DATA_VOTE(1), .CAPTURE_READS(1),
        .FILTER_LO(16'hC080), .FILTER_HI(16'hC08F)
    ) dut1 (
        .clk_logic_i(clk), .system_reset_i(rst),
        .phi1_i(phi1), .phi1_posedge_i(phi1_pe), .phi1_negedge_i(phi1_ne),
        .a2_a_i(a2_a), .a2_d_i(a2_d), .a2_rw_n_i(a2_rw_n),
        .cfg_addr_count_i(cfg_a), .cfg_data_count_i(cfg_d),
        .addr_o(addr1), .rw_n_o(rw1), .addr_strobe_o(as1),
        .data_o(data1), .data_in_strobe_o(ds1),
        .fifo_rd_i(fifo_rd1), .fifo_dout_o(dout1), .fifo_empty_o(empty1),
        .fifo_count_o(cnt1), .overflow_o(ovf1),
        .overflow_clr_i(ovf_clr1), .sleep_o(sleep1)
    );

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [5:0]  ca;
        logic [5:0]  cd;
        logic [7:0]  dm2;
        logic [7:0]  dm1;
        logic [7:0]  d0;
        logic [7:0]  ed0;
        logic [7:0]  ed1;
        int          ec0;
        int          ec1;
        logic        eo0;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One 52-cycle bus cycle: 26 Phi1 cycles then 26 Phi0 cycles.
    // Count x of a phase falls in phase cycle k = x+1.
    task automatic bus_cycle(input logic [15:0] a, input logic rw,
                             input logic [7:0] dm2, input logic [7:0] dm1,
                             input logic [7:0] d0, input logic pop,
                             input string tag);
        int n_as = 0;
        int n_ds0 = 0;
        int n_ds1 = 0;
        int g_as = -1;
        int g_ds0 = -1;
        int g_ds1 = -1;
        int c = int'(cfg_d);
        int k;
        for (int g = 0; g < 52; g++) begin
            k = g % 26;
            @(negedge clk);
            if (as0) begin n_as++; g_as = g; end
            if (ds0) begin n_ds0++; g_ds0 = g; end
            if (ds1) begin n_ds1++; g_ds1 = g; end
            phi1    = (g < 26);
            phi1_pe = (g == 0);
            phi1_ne = (g == 26);
            a2_a    = a;
            a2_rw_n = rw;
            if (g < 26)          a2_d = 8'hE7;
            else if (k == c - 1) a2_d = dm2;
            else if (k == c)     a2_d = dm1;
            else if (k == c + 1) a2_d = d0;
            else                 a2_d = 8'hE7;
            fifo_rd0 = pop && (g >= 26) && (k == c + 1);
        end
        chk({tag, " addr strobe n"}, n_as, 1);
        chk({tag, " addr strobe pos"}, g_as, int'(cfg_a) + 2);
        chk({tag, " data strobe0 n"}, n_ds0, 1);
        chk({tag, " data strobe0 pos"}, g_ds0, 26 + c + 2);
        chk({tag, " data strobe1 pos"}, g_ds1, 26 + c + 2);
    endtask

    initial begin
        tv[0] = '{16'hC0A5, 1'b0, 6'd18, 6'd15, 8'h5A, 8'h5A, 8'h5A,
                  8'h5A, 8'h5A, 1, 0, 1'b0};
        tv[1] = '{16'hC085, 1'b1, 6'd18, 6'd15, 8'h33, 8'h33, 8'h33,
                  8'h5A, 8'h33, 1, 1, 1'b0};
        tv[2] = '{16'hC07F, 1'b0, 6'd18, 6'd15, 8'h11, 8'h11, 8'h11,
                  8'h11, 8'h11, 2, 1, 1'b0};
        tv[3] = '{16'hC080, 1'b0, 6'd18, 6'd15, 8'h22, 8'h22, 8'h22,
                  8'h22, 8'h22, 3, 2, 1'b0};
        tv[4] = '{16'hC08F, 1'b0, 6'd18, 6'd15, 8'h44, 8'h44, 8'h44,
                  8'h44, 8'h44, 4, 3, 1'b0};
        tv[5] = '{16'hC090, 1'b0, 6'd18, 6'd15, 8'h66, 8'h66, 8'h66,
                  8'h66, 8'h66, 4, 3, 1'b1};
        tv[6] = '{16'hC081, 1'b0, 6'd18, 6'd15, 8'h0F, 8'h33, 8'h55,
                  8'h55, 8'h17, 4, 4, 1'b1};
        tv[7] = '{16'hC082, 1'b0, 6'd18, 6'd15, 8'hFF, 8'h00, 8'hFF,
                  8'hFF, 8'hFF, 4, 5, 1'b1};
        tv[8] = '{16'hC083, 1'b0, 6'd18, 6'd1, 8'h00, 8'h00, 8'hA7,
                  8'hA7, 8'hA7, 4, 6, 1'b1};
        tv[9] = '{16'h1234, 1'b0, 6'd5, 6'd15, 8'h9C, 8'h9C, 8'h9C,
                  8'h9C, 8'h9C, 4, 6, 1'b1};

        @(negedge clk);
        @(negedge clk);
        chk("rst sleep", sleep0, 1);
        chk("rst addr", addr0, 0);
        chk("rst rw", rw0, 1);
        chk("rst data", data0, 0);
        chk("rst strobes", {as0, ds0, as1, ds1}, 0);
        chk("rst empty", {empty0, empty1}, 2'b11);
        chk("rst count", {cnt0, cnt1}, 0);
        chk("rst ovf", {ovf0, ovf1}, 0);
        chk("rst dout", dout0, 0);
        rst = 1'b0;

        // Pop on empty is ignored.
        @(negedge clk);
        fifo_rd0 = 1'b1;
        @(negedge clk);
        fifo_rd0 = 1'b0;
        chk("pop empty count", cnt0, 0);
        chk("pop empty flag", empty0, 1);

        for (int i = 0; i < 10; i++) begin
            cfg_a = tv[i].ca;
            cfg_d = tv[i].cd;
            bus_cycle(tv[i].a, tv[i].rw, tv[i].dm2, tv[i].dm1, tv[i].d0,
                      1'b0, $sformatf("v%0d", i));
            chk($sformatf("v%0d addr", i), addr0, tv[i].a);
            chk($sformatf("v%0d rw", i), rw0, tv[i].rw);
            chk($sformatf("v%0d addr1", i), {rw1, addr1}, {tv[i].rw, tv[i].a});
            chk($sformatf("v%0d data0", i), data0, tv[i].ed0);
            chk($sformatf("v%0d data1", i), data1, tv[i].ed1);
            chk($sformatf("v%0d count0", i), cnt0, tv[i].ec0);
            chk($sformatf("v%0d count1", i), cnt1, tv[i].ec1);
            chk($sformatf("v%0d ovf0", i), ovf0, tv[i].eo0);
            if (i == 0)
                chk("v0 head0", dout0, {1'b0, 16'hC0A5, 8'h5A});
        end
        chk("head1", dout1, {1'b1, 16'hC085, 8'h33});
        chk("ovf1", ovf1, 0);

        cfg_a = 6'd18;
        cfg_d = 6'd15;
        @(negedge clk);
        ovf_clr0 = 1'b1;
        @(negedge clk);
        ovf_clr0 = 1'b0;
        chk("ovf clear", ovf0, 0);

        // Push and pop in the same cycle while full.
        bus_cycle(16'h0001, 1'b0, 8'h77, 8'h77, 8'h77, 1'b1, "pp");
        chk("pp count", cnt0, 4);
        chk("pp ovf", ovf0, 0);
        chk("pp head", dout0, {1'b0, 16'hC07F, 8'h11});
        chk("pp count1", cnt1, 6);

        @(negedge clk);
        fifo_rd0 = 1'b1;
        @(negedge clk);
        fifo_rd0 = 1'b0;
        chk("pop count", cnt0, 3);
        chk("pop head", dout0, {1'b0, 16'hC080, 8'h22});

        // Idle bus: counter saturates 63 cycles after the last edge.
        @(negedge clk);
        phi1 = 1'b1;
        phi1_pe = 1'b1;
        @(negedge clk);
        phi1_pe = 1'b0;
        for (int j = 1; j <= 63; j++) begin
            @(negedge clk);
            if (j == 62) chk("sleep at 62", sleep0, 0);
            if (j == 63) chk("sleep at 63", {sleep0, sleep1}, 2'b11);
        end
        phi1 = 1'b0;
        phi1_ne = 1'b1;
        @(negedge clk);
        phi1_ne = 1'b0;
        chk("sleep exit", sleep0, 0);

        for (int j = 0; j < 8; j++) @(negedge clk);
        chk("pre-rst count", cnt0, 3);
        #1 rst = 1'b1;
        #1;
        chk("arst sleep", sleep0, 1);
        chk("arst addr", {addr0, rw0}, {16'h0000, 1'b1});
        chk("arst data", {data0, data1}, 0);
        chk("arst fifo", {empty0, cnt0, empty1, cnt1}, {1'b1, 3'd0, 1'b1, 5'd0});
        chk("arst dout", {dout0, dout1}, 0);
        chk("arst ovf", {ovf0, as0, ds0}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
